vram_arbiter: RTL and testbench

- Shares one single-port synchronous VRAM (600 x 32) between two requesters: the Avalon-MM slave port (CPU text writes and reads) and the video glyph-fetch path (one word per 4 characters).
- Sits between the Avalon interface and the external vram_ram instance, and owns the text control register at word 600.
- Video always has priority. Avalon accesses are stalled with waitrequest.

---
 rtl/vram_arbiter_pkg.sv | 16 +
 rtl/vram_arbiter_if.sv | 24 ++
 rtl/vram_arbiter.sv | 97 +++++++++
 tb/tb_vram_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared constants and types for the text-mode VRAM arbiter.
package vga_text_pkg;

    localparam int VRAM_WORDS = 600;   // 80x30 characters, 4 per word
    localparam int CTRL_ADDR  = 600;   // control register sits just past VRAM
    localparam int ADDR_W     = 10;

    // Colour fields inside CTRL_REG
    localparam int CTRL_BG_LSB     = 0;
    localparam int CTRL_FG_LSB     = 12;
    localparam int CTRL_COLOUR_W   = 12;
    localparam int CTRL_CURSOR_BIT = 24;

    typedef enum logic [1:0] {IDLE, RD, ACK} arb_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Avalon-MM slave bus between the CPU bridge and the VRAM arbiter.
interface vram_arbiter_if;
    import vga_text_pkg::*;

    logic              CS;
    logic              READ;
    logic              WRITE;
    logic [3:0]        BYTE_EN;
    logic [ADDR_W-1:0] ADDR;
    logic [31:0]       WRITEDATA;
    logic [31:0]       READDATA;
    logic              WAITREQUEST;

    modport master (
        output CS, READ, WRITE, BYTE_EN, ADDR, WRITEDATA,
        input  READDATA, WAITREQUEST
    );

    modport slave (
        input  CS, READ, WRITE, BYTE_EN, ADDR, WRITEDATA,
        output READDATA, WAITREQUEST
    );

endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between Avalon CPU accesses and video glyph
// fetches. Video always wins the RAM; Avalon is held off with waitrequest.
// Also owns the text control register at CTRL_ADDR.
module vram_arbiter
    import vga_text_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    vram_arbiter_if.slave     avl,
    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_ADDR,
    output logic [31:0]       VID_DATA,
    output logic              VID_VALID,
    output logic [31:0]       CTRL_REG,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [3:0]        RAM_BE,
    output logic [31:0]       RAM_WDATA,
    input  logic [31:0]       RAM_RDATA
);

    arb_state_t state;
    logic       req, is_wr, addr_ctrl, addr_oob, vid_hit, avl_grant;
    // vld_pipe[0]: fetch in flight (RAM data arriving); vld_pipe[1]: strobe
    logic [1:0] vld_pipe;
    logic       vid_oob_q;

    assign VID_VALID = vld_pipe[1];

    // Request decode and RAM grant; video and Avalon grants are exclusive
    // because Avalon only gets the RAM in a cycle with no VID_REQ.
    always_comb begin
        req       = avl.CS & (avl.READ | avl.WRITE);
        is_wr     = avl.WRITE;   // read+write together counts as a write
        addr_ctrl = (avl.ADDR == ADDR_W'(CTRL_ADDR));
        addr_oob  = (avl.ADDR >  ADDR_W'(CTRL_ADDR));
        vid_hit   = VID_REQ & (VID_ADDR < ADDR_W'(VRAM_WORDS));
        avl_grant = (state == IDLE) & req & ~addr_ctrl & ~addr_oob & ~VID_REQ;
        RAM_ADDR  = vid_hit ? VID_ADDR : avl.ADDR;
        // RESET_N gate keeps a write from landing once reset has fallen
        RAM_BE    = (avl_grant & is_wr & RESET_N) ? avl.BYTE_EN : 4'b0000;
        RAM_WDATA = avl.WRITEDATA;
        avl.WAITREQUEST = ~RESET_N | (req & (state != ACK));
    end

    // Video fetch pipeline: capture RAM data one cycle after the read, strobe next.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vld_pipe  <= '0;
            vid_oob_q <= 1'b0;
            VID_DATA  <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[0], VID_REQ};
            vid_oob_q <= ~vid_hit;
            if (vld_pipe[0])
                VID_DATA <= vid_oob_q ? 32'h0 : RAM_RDATA;
        end
    end

    // Avalon FSM: serves CTRL/out-of-range locally, otherwise waits for a free RAM cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            avl.READDATA <= '0;
            CTRL_REG     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (addr_ctrl) begin
                            if (is_wr) begin
                                for (int b = 0; b < 4; b++)
                                    if (avl.BYTE_EN[b])
                                        CTRL_REG[8*b +: 8] <= avl.WRITEDATA[8*b +: 8];
                            end else begin
                                avl.READDATA <= CTRL_REG;
                            end
                            state <= ACK;
                        end else if (addr_oob) begin
                            if (!is_wr)
                                avl.READDATA <= '0;
                            state <= ACK;
                        end else if (!VID_REQ) begin
                            state <= is_wr ? ACK : RD;
                        end
                    end
                end
                RD: begin
                    avl.READDATA <= RAM_RDATA;
                    state        <= ACK;
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural single-port VRAM.
module tb_vram_arbiter;
    import vga_text_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        VID_REQ;
    logic [9:0]  VID_ADDR;
    logic [31:0] VID_DATA;
    logic        VID_VALID;
    logic [31:0] CTRL_REG;
    logic [9:0]  RAM_ADDR;
    logic [3:0]  RAM_BE;
    logic [31:0] RAM_WDATA;
    logic [31:0] RAM_RDATA;

    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [0:599];

    int vecs = 0, errs = 0, bad_wr = 0, vv_cnt = 0;
    logic vid_req_q = 1'b0;

    always #10 CLK = ~CLK;

    vram_arbiter_if avl();

    vram_arbiter dut (
        .CLK(CLK), .RESET_N(RESET_N), .avl(avl),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_DATA(VID_DATA), .VID_VALID(VID_VALID),
        .CTRL_REG(CTRL_REG), .RAM_ADDR(RAM_ADDR), .RAM_BE(RAM_BE),
        .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
    );

    // Synchronous VRAM model with byte enables and a bench preload port
    always @(posedge CLK) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (RAM_BE != 4'b0 && RAM_ADDR < 10'd600)
            for (int b = 0; b < 4; b++)
                if (RAM_BE[b]) mem[RAM_ADDR][8*b +: 8] <= RAM_WDATA[8*b +: 8];
        RAM_RDATA <= (RAM_ADDR < 10'd600) ? mem[RAM_ADDR] : 32'h0;
        if (!RESET_N && RAM_BE != 4'b0) bad_wr++;
    end

    always @(negedge CLK) if (VID_VALID === 1'b1) vv_cnt++;

    // Stimulus must never raise VID_REQ in consecutive cycles
    always @(posedge CLK) begin
        assert (!(VID_REQ === 1'b1 && vid_req_q === 1'b1)) else $error("protocol violation: VID_REQ back to back");
        vid_req_q <= VID_REQ;
    end

    function automatic logic [31:0] pat(input int i);
        return 32'h5A000000 ^ (32'(i) * 32'h00010003);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        @(negedge CLK);
        pre_we = 1'b1; pre_addr = 10'(a); pre_data = d;
        @(negedge CLK);
        pre_we = 1'b0;
    endtask

    // mode: 0 read, 1 write, 2 read+write. cyc = cycle in which waitrequest
    // dropped (1 = first request cycle), 0 on timeout.
    task automatic xfer(input int mode, input int a, input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rd, output int cyc);
        @(negedge CLK);
        avl.CS = 1'b1; avl.READ = (mode != 1); avl.WRITE = (mode != 0);
        avl.ADDR = 10'(a); avl.WRITEDATA = d; avl.BYTE_EN = be;
        cyc = 0; rd = 'x;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (avl.WAITREQUEST === 1'b0) begin
                cyc = i; rd = avl.READDATA;
                break;
            end
            @(negedge CLK);
        end
        @(negedge CLK);
        avl.CS = 1'b0; avl.READ = 1'b0; avl.WRITE = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int cyc, snap;
        avl.CS = 1'b0; avl.READ = 1'b0; avl.WRITE = 1'b0; avl.BYTE_EN = 4'h0;
        avl.ADDR = '0; avl.WRITEDATA = '0;
        VID_REQ = 1'b0; VID_ADDR = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Reset state, with a write pending on the bus
        avl.CS = 1'b1; avl.WRITE = 1'b1; avl.BYTE_EN = 4'hF; avl.ADDR = 10'd5;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_waitreq",  32'(avl.WAITREQUEST), 32'd1);
        chk("rst_readdata", avl.READDATA, 32'h0);
        chk("rst_vid_data", VID_DATA, 32'h0);
        chk("rst_vid_valid", 32'(VID_VALID), 32'd0);
        chk("rst_ctrl", CTRL_REG, 32'h0);
        chk("rst_ram_be", 32'(RAM_BE), 32'h0);
        avl.CS = 1'b0; avl.WRITE = 1'b0; avl.BYTE_EN = 4'h0;
        @(negedge CLK);
        RESET_N = 1'b1;

        // Plain write to addr 5, cycle by cycle
        @(negedge CLK);
        avl.CS = 1'b1; avl.WRITE = 1'b1; avl.ADDR = 10'd5; avl.WRITEDATA = 32'h41424344; avl.BYTE_EN = 4'hF;
        #1;
        chk("wr5_c1_be", 32'(RAM_BE), 32'hF);
        chk("wr5_c1_addr", 32'(RAM_ADDR), 32'd5);
        chk("wr5_c1_wdata", RAM_WDATA, 32'h41424344);
        chk("wr5_c1_wait", 32'(avl.WAITREQUEST), 32'd1);
        @(negedge CLK); #1;
        chk("wr5_c2_wait", 32'(avl.WAITREQUEST), 32'd0);
        chk("wr5_c2_be", 32'(RAM_BE), 32'h0);
        @(negedge CLK);
        avl.CS = 1'b0; avl.WRITE = 1'b0;
        xfer(0, 5, 32'h0, 4'h0, rd, cyc);
        chk("rd5_data", rd, 32'h41424344);
        chk("rd5_lat", 32'(cyc), 32'd3);

        // Avalon write colliding with a video fetch of the same word
        preload(10, 32'h11111111);
        @(negedge CLK);
        avl.CS = 1'b1; avl.WRITE = 1'b1; avl.ADDR = 10'd10; avl.WRITEDATA = 32'h22222222; avl.BYTE_EN = 4'hF;
        VID_REQ = 1'b1; VID_ADDR = 10'd10;
        #1;
        chk("col_t0_be", 32'(RAM_BE), 32'h0);
        chk("col_t0_addr", 32'(RAM_ADDR), 32'd10);
        chk("col_t0_wait", 32'(avl.WAITREQUEST), 32'd1);
        @(negedge CLK);
        VID_REQ = 1'b0;
        #1;
        chk("col_t1_be", 32'(RAM_BE), 32'hF);
        chk("col_t1_wait", 32'(avl.WAITREQUEST), 32'd1);
        chk("col_t1_vvalid", 32'(VID_VALID), 32'd0);
        @(negedge CLK); #1;
        chk("col_t2_vvalid", 32'(VID_VALID), 32'd1);
        chk("col_t2_vdata", VID_DATA, 32'h11111111);
        chk("col_t2_wait", 32'(avl.WAITREQUEST), 32'd0);
        @(negedge CLK);
        avl.CS = 1'b0; avl.WRITE = 1'b0;
        #1;
        chk("col_t3_vvalid", 32'(VID_VALID), 32'd0);
        chk("col_t3_vhold", VID_DATA, 32'h11111111);
        xfer(0, 10, 32'h0, 4'h0, rd, cyc);
        chk("col_rd10", rd, 32'h22222222);

        // Byte-enable merge
        xfer(1, 3, 32'hFFFFFFFF, 4'hF, rd, cyc);
        chk("be_wr_lat", 32'(cyc), 32'd2);
        xfer(1, 3, 32'h000000AA, 4'b0001, rd, cyc);
        xfer(0, 3, 32'h0, 4'h0, rd, cyc);
        chk("be_merge", rd, 32'hFFFFFFAA);

        // CTRL write with a video request in the same cycle
        @(negedge CLK);
        avl.CS = 1'b1; avl.WRITE = 1'b1; avl.ADDR = 10'd600; avl.WRITEDATA = 32'h01FFE000; avl.BYTE_EN = 4'hF;
        VID_REQ = 1'b1; VID_ADDR = 10'd20;
        #1;
        chk("ctrl_c1_be", 32'(RAM_BE), 32'h0);
        chk("ctrl_c1_wait", 32'(avl.WAITREQUEST), 32'd1);
        @(negedge CLK);
        VID_REQ = 1'b0;
        #1;
        chk("ctrl_c2_wait", 32'(avl.WAITREQUEST), 32'd0);
        chk("ctrl_reg", CTRL_REG, 32'h01FFE000);
        @(negedge CLK);
        avl.CS = 1'b0; avl.WRITE = 1'b0;
        xfer(0, 600, 32'h0, 4'h0, rd, cyc);
        chk("ctrl_rd", rd, 32'h01FFE000);
        chk("ctrl_rd_lat", 32'(cyc), 32'd2);
        xfer(1, 600, 32'h000000AB, 4'b0001, rd, cyc);
        chk("ctrl_be", CTRL_REG, 32'h01FFE0AB);
        xfer(1, 700, 32'hDEADBEEF, 4'hF, rd, cyc);
        chk("oob_wr_lat", 32'(cyc), 32'd2);
        chk("oob_wr_ctrl", CTRL_REG, 32'h01FFE0AB);
        xfer(0, 700, 32'h0, 4'h0, rd, cyc);
        chk("oob_rd", rd, 32'h0);
        chk("oob_rd_lat", 32'(cyc), 32'd2);

        // BE=0 write completes without touching RAM; read+write acts as write
        xfer(1, 5, 32'hFFFFFFFF, 4'h0, rd, cyc);
        chk("be0_lat", 32'(cyc), 32'd2);
        xfer(0, 5, 32'h0, 4'h0, rd, cyc);
        chk("be0_keep", rd, 32'h41424344);
        xfer(2, 7, 32'h00000077, 4'hF, rd, cyc);
        chk("rw_lat", 32'(cyc), 32'd2);
        xfer(0, 7, 32'h0, 4'h0, rd, cyc);
        chk("rw_data", rd, 32'h00000077);

        // Video sweep over the whole VRAM
        for (int i = 0; i < 600; i++) preload(i, pat(i));
        repeat (4) @(negedge CLK);
        snap = vv_cnt;
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            VID_REQ = 1'b1; VID_ADDR = 10'(i);
            @(negedge CLK);
            VID_REQ = 1'b0;
            @(negedge CLK); #1;
            chk($sformatf("sweep_%0d", i), VID_DATA, pat(i));
            repeat (61) @(negedge CLK);
        end
        chk("sweep_pulses", 32'(vv_cnt - snap), 32'd600);

        // Out-of-range video address
        @(negedge CLK);
        VID_REQ = 1'b1; VID_ADDR = 10'd650;
        @(negedge CLK);
        VID_REQ = 1'b0;
        @(negedge CLK); #1;
        chk("vid_oob_valid", 32'(VID_VALID), 32'd1);
        chk("vid_oob_data", VID_DATA, 32'h0);

        // Reset during the RD state of a read
        xfer(0, 600, 32'h0, 4'h0, rd, cyc);
        chk("pre_rst_rd", rd, 32'h01FFE0AB);
        @(negedge CLK);
        avl.CS = 1'b1; avl.READ = 1'b1; avl.ADDR = 10'd5;
        @(negedge CLK); #1;
        chk("rd_state_wait", 32'(avl.WAITREQUEST), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_wait", 32'(avl.WAITREQUEST), 32'd1);
        chk("mid_rst_readdata", avl.READDATA, 32'h0);
        chk("mid_rst_ctrl", CTRL_REG, 32'h0);
        avl.READ = 1'b0; avl.WRITE = 1'b1; avl.BYTE_EN = 4'hF; avl.WRITEDATA = 32'hBAD0BAD0;
        #1;
        chk("mid_rst_be", 32'(RAM_BE), 32'h0);
        repeat (2) @(negedge CLK);
        #1;
        chk("mid_rst_readdata2", avl.READDATA, 32'h0);
        avl.CS = 1'b0; avl.WRITE = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        xfer(1, 5, 32'h12345678, 4'hF, rd, cyc);
        chk("post_rst_wr_lat", 32'(cyc), 32'd2);
        xfer(0, 5, 32'h0, 4'h0, rd, cyc);
        chk("post_rst_rd", rd, 32'h12345678);
        chk("no_write_in_reset", 32'(bad_wr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
